// File: rtl/piso_shift6_pkg.sv
// Shared definitions for the 6-bit serial link transmitter: state encoding and default word length.
package piso_shift6_pkg;

    localparam int unsigned PISO_DEF_WIDTH = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry word buffer that lets the next word wait while the current one is shifting out.
module piso_hold_buf
    import piso_shift6_pkg::*;
#(
    parameter int WIDTH = PISO_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    // Storage and occupancy; a read and a write on the same edge leaves the buffer full with the new word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= {WIDTH{1'b0}};
            r_full <= 1'b0;
        end else begin
            if (i_wr) begin
                r_data <= i_data;
            end
            case ({i_wr, i_rd})
                2'b10:   r_full <= 1'b1;
                2'b01:   r_full <= 1'b0;
                2'b11:   r_full <= 1'b1;
                default: r_full <= r_full;
            endcase
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/piso_shift6.sv
// Parallel-in/serial-out transmitter: one word per WIDTH clocks on w/w_valid, with a one-word queue
// so consecutive words go out back-to-back.
module piso_shift6
    import piso_shift6_pkg::*;
#(
    parameter int WIDTH     = PISO_DEF_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    piso_state_e      r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic             w_hold_wr;
    logic             w_hold_rd;
    logic             w_hold_full;
    logic [WIDTH-1:0] w_hold_data;
    logic [WIDTH-1:0] w_sreg_shift;
    logic             w_out_bit;

    assign w_accept  = load_valid && load_ready;
    assign w_last    = (r_state == SHIFT) && (r_cnt == CNT_LAST);
    // A word arriving on the last-bit edge with the buffer empty bypasses it straight into sreg.
    assign w_hold_wr = w_accept && (r_state == SHIFT) && !w_last;
    assign w_hold_rd = w_last && w_hold_full;

    piso_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk    (clk),
        .reset  (reset),
        .i_wr   (w_hold_wr),
        .i_data (din),
        .i_rd   (w_hold_rd),
        .o_data (w_hold_data),
        .o_full (w_hold_full)
    );

    // Shift toward the output end with zero fill, and select the output end of sreg.
    always_comb begin
        w_sreg_shift = {WIDTH{1'b0}};
        w_out_bit    = 1'b0;
        if (MSB_FIRST != 0) begin
            w_sreg_shift = {r_sreg[WIDTH-2:0], 1'b0};
            w_out_bit    = r_sreg[WIDTH-1];
        end else begin
            w_sreg_shift = {1'b0, r_sreg[WIDTH-1:1]};
            w_out_bit    = r_sreg[0];
        end
    end

    // Framing FSM: load, shift, and chain into the held or bypassed word at the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sreg  <= {WIDTH{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sreg  <= din;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        r_done <= 1'b1;
                        r_cnt  <= {CNT_W{1'b0}};
                        if (w_hold_full) begin
                            r_sreg <= w_hold_data;
                        end else if (w_accept) begin
                            r_sreg <= din;
                        end else begin
                            r_sreg  <= {WIDTH{1'b0}};
                            r_state <= IDLE;
                        end
                    end else begin
                        r_sreg <= w_sreg_shift;
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sreg  <= {WIDTH{1'b0}};
                    r_cnt   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign w          = w_out_bit;
    assign w_valid    = (r_state == SHIFT);
    assign busy       = (r_state == SHIFT) || w_hold_full;
    assign done       = r_done;
    assign load_ready = !w_hold_full;

endmodule
